muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair for the pipelined MIPS core.
- Sits beside the EX-stage ALU. It accepts mult/div and mfhi/mflo requests using the ALU op encoding, iterates one bit per cycle, and raises a pipeline stall while a result is pending.
- It replaces single-cycle combinational multiply/divide and lets HI/LO persist across instructions.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; an operation takes WIDTH iterations.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- valid  in  1  EX-stage instruction present this cycle
- op  in  4  ALU op code: 3=mfhi, 4=mflo, 5=mult, 8=div; others ignored
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt)
- abort  in  1  pipeline flush; cancels an in-flight operation
- stall  out  1  hold EX and earlier stages
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse when HI/LO are written
- result  out  WIDTH  mfhi/mflo read data
- hi  out  WIDTH  current HI register
- lo  out  WIDTH  current LO register

Behaviour:
- Reset values: state=IDLE, count=0, HI=0, LO=0, busy=0, done=0. stall and result follow from this state (result=0).
- Reset asserted mid-operation: abandon the operation immediately; HI/LO clear to 0.
- States: IDLE, MUL, DIV.
- IDLE -> MUL on valid&&op==5; IDLE -> DIV on valid&&op==8. Operands are latched on that edge (call it T0), and count is loaded with WIDTH.
- MUL: shift-add, one multiplier bit per cycle. Accumulator is 2*WIDTH wide.
- DIV: restoring division, one quotient bit per cycle. Remainder register is WIDTH+1 bits.
- busy=1 for exactly WIDTH cycles after T0. On edge T0+WIDTH:
  - mult: {HI,LO} <= a*b (full 2*WIDTH-bit unsigned product).
  - div: LO <= a/b, HI <= a%b (unsigned).
  - state returns to IDLE, and done=1 for the single following cycle.
- Divide by zero needs no special case. The restoring algorithm yields LO=all ones and HI=a; this is the required result.
- stall = valid && busy && op in {3,4,5,8}.
  - A new mult/div issued while busy is held, not queued. It is accepted on the first cycle busy=0.
  - Other ops never stall.
- result = HI when op==3, LO when op==4, else 0. It is combinational from the registers, so HI/LO written at T0+WIDTH are visible on the same cycle done=1.
- A read issued in the same cycle a new mult/div is accepted from IDLE returns the old HI/LO. Such a request is only possible on separate instructions, so this is a bench check only.
- abort=1:
  - While busy: next edge returns to IDLE, busy=0, no done pulse, HI/LO unchanged.
  - In IDLE: abort has priority over a start in the same cycle, so no operation is accepted.
- valid with an unrecognised op: no state change.
- All arithmetic is unsigned modulo 2^WIDTH per register. No overflow flag.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- When defined, adds op 13=mult signed and op 14=div signed. Both use the same WIDTH-cycle timing and stall rules as ops 5/8.
- Signed handling: iterate on operand magnitudes, then negate the results.
  - Product sign = sign(a) xor sign(b).
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Negation is applied on the final edge, with no extra cycle.
- Special cases:
  - Most-negative / -1: LO=0x80000000, HI=0.
  - Signed divide by zero: LO=all ones, HI=a.
- When not defined, ops 13/14 are unrecognised: no stall, no state change.

Test Plan:
- Reset then valid op=3, then op=4 -> result=0 both cycles, stall=0.
- mult a=0xFFFFFFFF b=0xFFFFFFFF -> busy for exactly 32 cycles; HI=0xFFFFFFFE, LO=0x00000001; done pulses once.
- div a=100 b=7, then mflo issued 5 cycles later -> stall=1 until busy falls; result=14 (LO); following mfhi returns 2.
- div a=0x12345678 b=0 -> LO=0xFFFFFFFF, HI=0x12345678.
- mult a=3 b=5, abort asserted at cycle 10 -> busy=0 next cycle, no done pulse, HI/LO keep their prior values; async rst mid-div clears HI=LO=0 immediately.
- With MULDIV_SIGNED_EN: op=14 a=-7 b=2 -> LO=-3, HI=-1; op=13 a=-2 b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Without the macro, op=13 produces no busy.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer that owns the architectural HI/LO
//   pair. It iterates one bit per cycle (shift-add multiply, restoring divide)
//   and stalls the pipeline when a dependent request arrives while it is busy.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active high
//   valid   in   EX-stage instruction present
//   op      in   ALU op: 3=mfhi 4=mflo 5=mult 8=div (13/14 signed, optional)
//   a, b    in   operands (rs, rt)
//   abort   in   pipeline flush, cancels an in-flight operation
//   stall   out  hold EX and earlier stages
//   busy    out  iteration in progress
//   done    out  one-cycle pulse after HI/LO are written
//   result  out  mfhi/mflo read data (combinational)
//   hi, lo  out  current HI/LO registers
//
// Optional feature: define MULDIV_SIGNED_EN to add op 13 (signed mult) and
// op 14 (signed div). Without it those ops are ignored.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MFHI = 4'd3;
    localparam logic [3:0] OP_MFLO = 4'd4;
    localparam logic [3:0] OP_MULT = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd8;
`ifdef MULDIV_SIGNED_EN
    localparam logic [3:0] OP_MULTS = 4'd13;
    localparam logic [3:0] OP_DIVS  = 4'd14;
`endif

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // MUL: {partial, multiplier}; DIV: low half = quotient/dividend
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               negq_q, negq_d;   // negate product / quotient on final edge
    logic               negr_q, negr_d;   // negate remainder on final edge

    logic               start_mul, start_div, sgn_op, md_op;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    // Request decode and operand magnitudes
    always_comb begin
        start_mul = valid && (op == OP_MULT);
        start_div = valid && (op == OP_DIV);
        sgn_op    = 1'b0;
        md_op     = (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_SIGNED_EN
        if (valid && (op == OP_MULTS)) begin
            start_mul = 1'b1;
            sgn_op    = 1'b1;
        end
        if (valid && (op == OP_DIVS)) begin
            start_div = 1'b1;
            sgn_op    = 1'b1;
        end
        md_op = md_op || (op == OP_MULTS) || (op == OP_DIVS);
`endif
        a_mag = (sgn_op && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn_op && b[WIDTH-1]) ? -b : b;
    end

    // One iteration step for each algorithm
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opnd_q};
        div_ge    = !div_diff[WIDTH+1];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        negq_d  = negq_q;
        negr_d  = negr_q;
        prod    = '0;

        case (state_q)
            S_IDLE: begin
                if (!abort && (start_mul || start_div)) begin
                    state_d = start_mul ? S_MUL : S_DIV;
                    count_d = CW'(WIDTH);
                    acc_d   = {{WIDTH{1'b0}}, (start_mul ? b_mag : a_mag)};
                    opnd_d  = start_mul ? a_mag : b_mag;
                    rem_d   = '0;
                    // A zero divisor keeps the all-ones quotient unsigned-looking
                    negq_d  = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (start_mul || (b != '0));
                    negr_d  = sgn_op && a[WIDTH-1];
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            S_DIV: begin
                rem_d = div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            count_d = count_q - CW'(1);
            if (abort) begin
                state_d = S_IDLE;
            end else if (count_q == CW'(1)) begin
                // Last iteration: result goes straight from the step logic to HI/LO
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (state_q == S_MUL) begin
                    prod = negq_q ? -acc_d : acc_d;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    lo_d = negq_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
                    hi_d = negr_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    always_comb begin
        result = '0;
        if (op == OP_MFHI) begin
            result = hi_q;
        end else if (op == OP_MFLO) begin
            result = lo_q;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = valid && busy && md_op;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed cases plus randomized mult/div against
// a plain-arithmetic reference model, with a done-driven scoreboard monitor.
module tb_muldiv_ctrl;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, valid, abort;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         stall, busy, done;
    logic [W-1:0] result, hi, lo;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .a(a), .b(b),
        .abort(abort), .stall(stall), .busy(busy), .done(done),
        .result(result), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: results straight from integer arithmetic
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.hi = '0;
        e.lo = '0;
        case (o)
            4'd5: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            4'd8: begin
                if (y == 0) begin e.lo = '1; e.hi = x; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
            4'd13: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            4'd14: begin
                if (y == 0) begin e.lo = '1; e.hi = x; end
                else begin
                    p = sx / sy;
                    e.lo = p[31:0];
                    p = sx % sy;
                    e.hi = p[31:0];
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one cycle; returns 1ns after the accepting edge
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        tick();
        valid = 1'b1; op = o; a = x; b = y;
        tick();
        valid = 1'b0; op = 4'd0;
    endtask

    // Count busy cycles; returns on the negedge where busy has dropped
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic md(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        exp_t e;
        int   n, d0;
        e = model(o, x, y);
        exp_q.push_back(e);
        d0 = done_cnt;
        issue(o, x, y);
        wait_idle(n);
        check({tag, "_busy_cycles"}, W'(n), W'(W));
        m_hi = e.hi;
        m_lo = e.lo;
        valid = 1'b1; op = 4'd3;
        #1 check({tag, "_mfhi"}, result, m_hi);
        check_b({tag, "_read_stall"}, stall, 1'b0);
        op = 4'd4;
        #1 check({tag, "_mflo"}, result, m_lo);
        valid = 1'b0; op = 4'd0;
        @(negedge clk);
        check_b({tag, "_done_single"}, done, 1'b0);
        check({tag, "_done_count"}, W'(done_cnt), W'(d0 + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t         e1, e2;
        int           n, d0;
        logic [W-1:0] old_hi, old_lo, x, y;
        logic [3:0]   o;

        rst = 1'b1; valid = 1'b0; abort = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_stall", stall, 1'b0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);

        // Reads right after reset
        tick(); valid = 1'b1; op = 4'd3;
        @(negedge clk);
        check("rst_mfhi", result, '0);
        check_b("rst_mfhi_stall", stall, 1'b0);
        tick(); op = 4'd4;
        @(negedge clk);
        check("rst_mflo", result, '0);
        check_b("rst_mflo_stall", stall, 1'b0);

        // Unrecognised ops never start anything
        tick(); op = 4'd7; a = 32'd9; b = 32'd9;
        @(negedge clk);
        check_b("op7_no_busy", busy, 1'b0);
`ifndef MULDIV_SIGNED_EN
        tick(); op = 4'd13;
        @(negedge clk);
        check_b("op13_no_busy", busy, 1'b0);
        tick(); op = 4'd14;
        @(negedge clk);
        check_b("op14_no_busy", busy, 1'b0);
`endif
        tick(); valid = 1'b0; op = 4'd0;

        md(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_max");
        check("mult_max_hi", hi, 32'hFFFF_FFFE);
        check("mult_max_lo", lo, 32'h0000_0001);

        // div 100/7 with an mflo arriving 5 cycles later
        old_lo = m_lo;
        e1 = model(4'd8, 32'd100, 32'd7);
        exp_q.push_back(e1);
        issue(4'd8, 32'd100, 32'd7);
        repeat (4) tick();
        valid = 1'b1; op = 4'd4;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            check_b("div_stall_while_busy", stall, 1'b1);
            check("div_read_old_lo", result, old_lo);
        end
        check_b("div_stall_release", stall, 1'b0);
        check("div_mflo", result, 32'd14);
        tick(); op = 4'd3;
        @(negedge clk);
        check("div_mfhi", result, 32'd2);
        tick(); valid = 1'b0; op = 4'd0;
        m_hi = e1.hi; m_lo = e1.lo;

        md(4'd8, 32'h1234_5678, 32'd0, "div_zero");
        check("div_zero_lo", lo, 32'hFFFF_FFFF);
        check("div_zero_hi", hi, 32'h1234_5678);

        // A div held behind a busy mult is accepted as soon as busy drops
        e1 = model(4'd5, 32'hDEAD_BEEF, 32'h0000_1234);
        e2 = model(4'd8, 32'hCAFE_F00D, 32'h0000_0013);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        d0 = done_cnt;
        old_hi = m_hi;
        issue(4'd5, 32'hDEAD_BEEF, 32'h0000_1234);
        valid = 1'b1; op = 4'd8; a = 32'hCAFE_F00D; b = 32'h0000_0013;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            check_b("hold_stall", stall, 1'b1);
        end
        check_b("hold_release_stall", stall, 1'b0);
        tick(); valid = 1'b0; op = 4'd0;
        wait_idle(n);
        check("hold_second_busy", W'(n), W'(W));
        @(negedge clk);
        check("hold_done_count", W'(done_cnt), W'(d0 + 2));
        m_hi = e2.hi; m_lo = e2.lo;
        check_b("hold_hi_changed", (m_hi != old_hi) ? (hi == m_hi) : 1'b1, 1'b1);

        // Abort at cycle 10 of mult 3*5
        d0 = done_cnt;
        issue(4'd5, 32'd3, 32'd5);
        repeat (4) tick();
        valid = 1'b1; op = 4'd2;
        @(negedge clk);
        check_b("other_op_no_stall", stall, 1'b0);
        check_b("abort_pre_busy", busy, 1'b1);
        tick(); valid = 1'b0; op = 4'd0;
        repeat (3) tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        @(negedge clk);
        check_b("abort_busy_clear", busy, 1'b0);
        repeat (40) tick();
        @(negedge clk);
        check("abort_no_done", W'(done_cnt), W'(d0));
        check("abort_hi_keep", hi, m_hi);
        check("abort_lo_keep", lo, m_lo);

        // Abort wins over a start from IDLE
        tick(); valid = 1'b1; op = 4'd5; a = 32'd7; b = 32'd7; abort = 1'b1;
        tick(); valid = 1'b0; op = 4'd0; abort = 1'b0;
        @(negedge clk);
        check_b("abort_idle_no_start", busy, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
`ifdef MULDIV_SIGNED_EN
            case ($urandom_range(0, 3))
                0: o = 4'd5;
                1: o = 4'd8;
                2: o = 4'd13;
                default: o = 4'd14;
            endcase
`else
            o = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd8;
`endif
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = W'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) y = '0;
            md(o, x, y, "rand");
        end

`ifdef MULDIV_SIGNED_EN
        md(4'd14, 32'hFFFF_FFF9, 32'd2, "sdiv");
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);
        md(4'd13, 32'hFFFF_FFFE, 32'd3, "smul");
        check("smul_hi", hi, 32'hFFFF_FFFF);
        check("smul_lo", lo, 32'hFFFF_FFFA);
        md(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        check("sdiv_ovf_lo", lo, 32'h8000_0000);
        check("sdiv_ovf_hi", hi, 32'h0000_0000);
        md(4'd14, 32'hFFFF_FFFB, 32'd0, "sdiv_zero");
        check("sdiv_zero_lo", lo, 32'hFFFF_FFFF);
        check("sdiv_zero_hi", hi, 32'hFFFF_FFFB);
`endif

        // Asynchronous reset in the middle of a div
        check_b("pre_rst_hilo_nonzero", (hi != '0) || (lo != '0), 1'b1);
        issue(4'd8, 32'hFFFF_0000, 32'd3);
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        check("async_rst_hi", hi, '0);
        check("async_rst_lo", lo, '0);
        check_b("async_rst_busy", busy, 1'b0);
        tick(); rst = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (40) tick();
        @(negedge clk);
        check_b("post_rst_idle", busy, 1'b0);
        check("post_rst_hi", hi, m_hi);

        check("scoreboard_empty", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
